alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 64-bit ALU datapath among NREQ requesters (e.g. execute stage, address generator, debug port). A round-robin grant selects one request per transaction, registers its operands and opcode, sequences the ALU through a three-state FSM, and returns the result, zero flag and requester ID over a valid/ready response channel. The block sits between the requesting units and the combinational `alu` instance it owns.

## Interface
- NREQ, 4: number of requesters; 2..8.
- W, 64: operand and result width.
- IDW, $clog2(NREQ): width of the requester ID.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*W  operand A, requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- req_sel  in  NREQ*4  ALU_Sel code, requester i at [i*4 +: 4].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  W  ALU result.
- rsp_zero  out  1  1 when rsp_data == 0.
- rsp_id  out  IDW  index of the requester served.
- rsp_err  out  1  illegal opcode; present only with ALU_ARB_OPCHK_EN.
- busy  out  1  high whenever state != IDLE.

## Operation
- Opcodes: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB. Arithmetic is modulo 2^W; carry and overflow are discarded.
- FSM states:
  - IDLE: if any req_valid, grant and go to EXEC, else stay.
  - EXEC: unconditionally go to RESP.
  - RESP: if rsp_ready, go to IDLE, else stay.
- Grant: round-robin starting at pointer ptr, searching ptr, ptr+1, … modulo NREQ. Takes the first requester with req_valid=1.
- req_ready[g] = (state==IDLE) & grant[g]. It is combinational from req_valid and ptr. Requesters must not make req_valid depend on req_ready.
- On accept (req_valid[g] & req_ready[g]):
  - capture req_a/req_b/req_sel of g into op_a/op_b/op_sel;
  - set id_q = g;
  - set ptr = (g+1) mod NREQ.
- EXEC: the ALU computes from op_a/op_b/op_sel. The result is registered into rsp_data at the end of EXEC, together with rsp_zero (result == 0) and rsp_id = id_q.
- RESP: rsp_valid=1. rsp_data, rsp_zero, rsp_id and rsp_err stay stable until rsp_ready is sampled high.
- A requester that drops req_valid before being granted loses nothing. Once accepted, a request cannot be withdrawn.
- Reset values: state=IDLE, ptr=0, op_* = 0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0, rsp_err=0, req_ready=0, busy=0.
- Reset mid-transaction: the in-flight operation is dropped and no response is produced.

## Timing
- Accept in cycle N → rsp_valid high from cycle N+2.
- Handshake completes in the first cycle ≥ N+2 with rsp_ready=1. The next accept can occur one cycle later.
- Peak throughput: one operation per 3 cycles. Each extra cycle of rsp_ready=0 adds one cycle.
- Fairness: a continuously valid requester is granted within NREQ transactions.
- Simultaneous requests are resolved by ptr order only; there are no fixed priorities.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - a sel code outside {0000, 0001, 0010, 0110} sets rsp_err=1 and forces rsp_data=0, rsp_zero=1;
  - the transaction otherwise completes normally.
- ALU_ARB_OPCHK_EN undefined:
  - no rsp_err port;
  - an illegal code produces rsp_data=0, rsp_zero=1, with no indication.
  - rsp_data is still never X.

## Structure
- Package alu_pkg holds:
  - opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB;
  - the FSM state enum (IDLE, EXEC, RESP);
  - an opcode-legal helper function.
- Sub-module rr_arbiter (parameter NREQ), with:
  - inputs req[NREQ-1:0] and ptr;
  - outputs one-hot gnt and encoded gnt_id.
- The ALU itself is one instance of the existing `alu` module, driven from op_a/op_b/op_sel.

## Test plan
- Single request from requester 2: A=5, B=3, sel=0010, accepted in cycle N → rsp_valid at N+2, rsp_data=8, rsp_zero=0, rsp_id=2.
- SUB A=7, B=7 → rsp_data=0, rsp_zero=1. SUB A=0, B=1 → rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
- All four requesters valid continuously after reset → grant order 0, 1, 2, 3, 0; each gets exactly one grant per 4 transactions.
- rsp_ready held low 5 cycles in RESP:
  - rsp_* stay stable;
  - all req_ready stay 0;
  - busy=1;
  - the next accept occurs the cycle after rsp_ready rises.
- Reset asserted during EXEC → all outputs return to reset values immediately and no response appears. The first grant after reset goes to requester 0.
- sel=4'b1111 with ALU_ARB_OPCHK_EN defined → rsp_err=1, rsp_data=0, rsp_zero=1. Without the macro → rsp_data=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode legality helper for alu_arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for the four opcodes the ALU implements.
  function automatic logic op_legal(input logic [3:0] sel);
    logic legal;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU; unknown opcodes yield zero so the result is never X.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   alu_sel,
  output logic [W-1:0] alu_out
);

  // Opcode decode; carry and overflow are discarded (modulo 2^W).
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_AND: alu_out = a & b;
      ALU_OR:  alu_out = a | b;
      ALU_ADD: alu_out = a + b;
      ALU_SUB: alu_out = a - b;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  // Scan ptr, ptr+1, ... and grant the first requester found.
  always_comb begin
    logic           found;
    logic [IDW:0]   idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req[idx[IDW-1:0]]) begin
        found                = 1'b1;
        gnt[idx[IDW-1:0]]    = 1'b1;
        gnt_id               = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant and a
// valid/ready response channel. Optional macro ALU_ARB_OPCHK_EN adds the
// rsp_err port flagging illegal opcodes.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 64,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_zero,
  output logic [IDW-1:0]  rsp_id,
`ifdef ALU_ARB_OPCHK_EN
  output logic            rsp_err,
`endif
  output logic            busy
);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [3:0]      op_sel;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  ptr_next;
  logic [W-1:0]    alu_out;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [3:0]      sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  alu #(
    .W (W)
  ) u_alu (
    .a       (op_a),
    .b       (op_b),
    .alu_sel (op_sel),
    .alu_out (alu_out)
  );

  // Grant is only offered in IDLE and never while reset is asserted.
  assign req_ready = (rst_n && (state == IDLE)) ? gnt : '0;
  assign busy      = (state != IDLE);
  assign ptr_next  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // One-hot operand mux selecting the granted requester's payload.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_sel[i*4 +: 4];
      end
    end
  end

  // Transaction FSM: accept in IDLE, compute in EXEC, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
`ifdef ALU_ARB_OPCHK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_sel <= sel_op;
            id_q   <= gnt_id;
            ptr    <= ptr_next;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= (alu_out == '0);
          rsp_id    <= id_q;
`ifdef ALU_ARB_OPCHK_EN
          rsp_err   <= !op_legal(op_sel);
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NREQ=4, W=64).
module tb_alu_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 64;
  localparam int unsigned IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_a;
  logic [NREQ*W-1:0]  req_b;
  logic [NREQ*4-1:0]  req_sel;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_data;
  logic               rsp_zero;
  logic [IDW-1:0]     rsp_id;
`ifdef ALU_ARB_OPCHK_EN
  logic               rsp_err;
`endif
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id),
`ifdef ALU_ARB_OPCHK_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s);
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_sel[i*4 +: 4] = s;
  endtask

  // One transaction from requester id with rsp_ready held high.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, output logic [W-1:0] d, output logic z,
                        output logic [IDW-1:0] rid, output logic e, output bit to);
    int k;
    to = 1'b0;
    @(posedge clk); #1;
    set_op(id, a, b, s);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    @(negedge clk);
    k = 0;
    while (req_ready[id] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (req_ready[id] !== 1'b1) to = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (rsp_valid !== 1'b1) to = 1'b1;
    d   = rsp_data;
    z   = rsp_zero;
    rid = rsp_id;
`ifdef ALU_ARB_OPCHK_EN
    e = rsp_err;
`else
    e = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    n_checks++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    n_checks++; if (rsp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_zero got=%0h exp=0", rsp_zero); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    n_checks++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
`ifdef ALU_ARB_OPCHK_EN
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%0h exp=0", rsp_err); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int t0;
    int k;
    @(posedge clk); #1;
    set_op(2, 64'd5, 64'd3, 4'b0010);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    t0 = cyc;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready got=%0h exp=4", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (cyc - t0 !== 2) begin n_fail++; $display("FAIL single_latency got=%0d exp=2", cyc - t0); end
    n_checks++; if (rsp_data !== 64'd8) begin n_fail++; $display("FAIL single_data got=%0h exp=8", rsp_data); end
    n_checks++; if (rsp_zero !== 1'b0) begin n_fail++; $display("FAIL single_zero got=%0h exp=0", rsp_zero); end
    n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0h exp=2", rsp_id); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%0h exp=1", busy); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done_valid got=%0h exp=0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_alu_ops;
    logic [W-1:0]   va  [5] = '{64'd7, 64'd0, 64'hF0F0, 64'hF0F0, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [W-1:0]   vb  [5] = '{64'd7, 64'd1, 64'hFF00, 64'hFF00, 64'd1};
    logic [3:0]     vs  [5] = '{4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0010};
    int             vid [5] = '{1, 1, 3, 0, 2};
    logic [W-1:0]   ed  [5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF000, 64'hFFF0, 64'd0};
    logic           ez  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0]   d;
    logic           z;
    logic           e;
    logic [IDW-1:0] rid;
    bit             to;
    for (int i = 0; i < 5; i++) begin
      run_op(vid[i], va[i], vb[i], vs[i], d, z, rid, e, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ops_timeout[%0d] got=%0h exp=0", i, to); end
      n_checks++; if (d !== ed[i]) begin n_fail++; $display("FAIL ops_data[%0d] got=%0h exp=%0h", i, d, ed[i]); end
      n_checks++; if (z !== ez[i]) begin n_fail++; $display("FAIL ops_zero[%0d] got=%0h exp=%0h", i, z, ez[i]); end
      n_checks++; if (rid !== IDW'(vid[i])) begin n_fail++; $display("FAIL ops_id[%0d] got=%0h exp=%0h", i, rid, vid[i]); end
    end
  endtask

  task automatic test_round_robin;
    int             k;
    int             prev;
    logic [3:0]     exp_gnt;
    logic [IDW-1:0] exp_id;
    prev = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_op(i, W'(i * 16), 64'd1, 4'b0010);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      exp_id  = IDW'(t % 4);
      exp_gnt = 4'b0001 << (t % 4);
      @(negedge clk);
      k = 0;
      while (req_ready === 4'd0 && k < 20) begin @(negedge clk); k++; end
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_grant[%0d] got=%0h exp=%0h", t, req_ready, exp_gnt); end
      if (t > 0) begin
        n_checks++; if (cyc - prev !== 3) begin n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", t, cyc - prev); end
      end
      prev = cyc;
      @(negedge clk);
      k = 0;
      while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_id[%0d] got=%0h exp=%0h", t, rsp_id, exp_id); end
      n_checks++; if (rsp_data !== W'((t % 4) * 16 + 1)) begin n_fail++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", t, rsp_data, (t % 4) * 16 + 1); end
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k;
    @(posedge clk); #1;
    set_op(3, 64'd100, 64'd58, 4'b0110);
    set_op(1, 64'h0F, 64'hF0, 4'b0001);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant got=%0h exp=8", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%0h exp=1", i, rsp_valid); end
      n_checks++; if (rsp_data !== 64'd42 || rsp_id !== 2'd3 || rsp_zero !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%0h/%0h/%0h exp=2a/3/0", i, rsp_data, rsp_id, rsp_zero); end
      n_checks++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, req_ready); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d] got=%0h exp=1", i, busy); end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'd0) begin
      n_fail++; $display("FAIL bp_release got=%0h/%0h exp=1/0", rsp_valid, req_ready); end
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant got=%0h exp=2", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_next_busy got=%0h exp=0", busy); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (rsp_data !== 64'hFF || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_second got=%0h/%0h exp=ff/1", rsp_data, rsp_id); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k;
    @(posedge clk); #1;
    set_op(2, 64'd1, 64'd1, 4'b0010);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_grant got=%0h exp=4", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_state got=%0h/%0h exp=0/0", busy, rsp_valid); end
    n_checks++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL rm_ready got=%0h exp=0", req_ready); end
    n_checks++; if (rsp_data !== 64'd0 || rsp_id !== 2'd0 || rsp_zero !== 1'b0) begin
      n_fail++; $display("FAIL rm_rsp got=%0h/%0h/%0h exp=0/0/0", rsp_data, rsp_id, rsp_zero); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp[%0d] got=%0h exp=0", i, rsp_valid); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant got=%0h exp=1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after_valid got=%0h exp=0", rsp_valid); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (rsp_id !== 2'd0 || rsp_data !== 64'd1) begin
      n_fail++; $display("FAIL rm_first_rsp got=%0h/%0h exp=0/1", rsp_id, rsp_data); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [W-1:0]   d;
    logic           z;
    logic           e;
    logic [IDW-1:0] rid;
    bit             to;
    run_op(0, 64'd5, 64'd3, 4'b1111, d, z, rid, e, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL illegal_timeout got=%0h exp=0", to); end
    n_checks++; if (d !== 64'd0) begin n_fail++; $display("FAIL illegal_data got=%0h exp=0", d); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL illegal_zero got=%0h exp=1", z); end
`ifdef ALU_ARB_OPCHK_EN
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%0h exp=1", e); end
    run_op(1, 64'd5, 64'd3, 4'b0010, d, z, rid, e, to);
    n_checks++; if (e !== 1'b0 || d !== 64'd8) begin n_fail++; $display("FAIL legal_err got=%0h/%0h exp=0/8", e, d); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_alu_ops();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
